// File: rtl/upcounter_chain_if.sv
// Key/tick inputs and display outputs of the mm:ss up-counting stopwatch.
// The lap signal exists only when LAP_HOLD_EN is defined.
interface upcounter_chain_if;
    logic        tick;
    logic        start_stop;
    logic        clear;
    logic [15:0] target;
`ifdef LAP_HOLD_EN
    logic        lap;
`endif
    logic [15:0] value;
    logic        carry;
    logic        running;
    logic        target_hit;

`ifdef LAP_HOLD_EN
    modport master (
        output tick, start_stop, clear, target, lap,
        input  value, carry, running, target_hit
    );
    modport slave (
        input  tick, start_stop, clear, target, lap,
        output value, carry, running, target_hit
    );
`else
    modport master (
        output tick, start_stop, clear, target,
        input  value, carry, running, target_hit
    );
    modport slave (
        input  tick, start_stop, clear, target,
        output value, carry, running, target_hit
    );
`endif
endinterface

// File: rtl/upcounter_chain.sv
// Four-digit BCD mm:ss up-counting stopwatch with an IDLE/RUN/PAUSE/DONE key FSM.
// Define LAP_HOLD_EN to add a lap key that freezes the displayed value while counting continues.
module upcounter_chain #(
    parameter logic [3:0] SEC_LO_MAX = 4'd9,
    parameter logic [3:0] SEC_HI_MAX = 4'd5,
    parameter logic [3:0] MIN_LO_MAX = 4'd9,
    parameter logic [3:0] MIN_HI_MAX = 4'd5
) (
    input logic              clk,
    input logic              rst,
    upcounter_chain_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e      state_q;
    logic [15:0] count_q, count_d, count_inc;
    logic        carry_q, carry_d;
    logic        running_q;
    logic        hit_q;
    logic [3:0]  at_max;
    logic        wrap;
    logic        step;
    logic        hit;

    // Digits above their limit count as "at max" so a stray value wraps instead of sticking.
    function automatic logic [3:0] bump(input logic [3:0] digit, input logic is_max,
                                        input logic en);
        if (!en) return digit;
        return is_max ? 4'd0 : digit + 4'd1;
    endfunction

    always_comb begin
        at_max[0] = count_q[3:0]   >= SEC_LO_MAX;
        at_max[1] = count_q[7:4]   >= SEC_HI_MAX;
        at_max[2] = count_q[11:8]  >= MIN_LO_MAX;
        at_max[3] = count_q[15:12] >= MIN_HI_MAX;
        count_inc[3:0]   = bump(count_q[3:0],   at_max[0], 1'b1);
        count_inc[7:4]   = bump(count_q[7:4],   at_max[1], at_max[0]);
        count_inc[11:8]  = bump(count_q[11:8],  at_max[2], &at_max[1:0]);
        count_inc[15:12] = bump(count_q[15:12], at_max[3], &at_max[2:0]);
        wrap = &at_max;
    end

    // A tick coinciding with either key is dropped.
    assign step = (state_q == StRun) && bus.tick && !bus.clear && !bus.start_stop;
    assign hit  = step && (bus.target != 16'h0000) && (count_inc == bus.target);

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (bus.clear) begin
            count_d = 16'h0000;
        end else if (step) begin
            count_d = count_inc;
            carry_d = wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
            hit_q     <= 1'b0;
            count_q   <= 16'h0000;
            carry_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            if (bus.clear) begin
                state_q   <= StIdle;
                running_q <= 1'b0;
                hit_q     <= 1'b0;
            end else if (bus.start_stop) begin
                case (state_q)
                    StIdle, StPause: begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                    end
                    StRun: begin
                        state_q   <= StPause;
                        running_q <= 1'b0;
                    end
                    default: state_q <= state_q;
                endcase
            end else if (hit) begin
                state_q   <= StDone;
                running_q <= 1'b0;
                hit_q     <= 1'b1;
            end
        end
    end

`ifdef LAP_HOLD_EN
    logic        hold_q, hold_d;
    logic [15:0] lap_q, lap_d;
    logic [15:0] value_q;

    always_comb begin
        hold_d = hold_q;
        lap_d  = lap_q;
        if (bus.clear) begin
            hold_d = 1'b0;
        end else if (!bus.start_stop && (state_q == StRun) && bus.lap) begin
            hold_d = !hold_q;
            lap_d  = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= 1'b0;
            lap_q   <= 16'h0000;
            value_q <= 16'h0000;
        end else begin
            hold_q  <= hold_d;
            lap_q   <= lap_d;
            value_q <= hold_d ? lap_d : count_d;
        end
    end

    assign bus.value = value_q;
`else
    assign bus.value = count_q;
`endif

    assign bus.carry      = carry_q;
    assign bus.running    = running_q;
    assign bus.target_hit = hit_q;

endmodule

// File: tb/tb_upcounter_chain.sv
// Self-checking bench for upcounter_chain: seconds-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key/tick traffic.
module tb_upcounter_chain;

    logic clk;
    logic rst;
    upcounter_chain_if bus ();

    upcounter_chain dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs;
    int checks;
    bit chk_en;

    // Reference model: time kept as plain seconds 0..3599, state as a small integer.
    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MPause = 2;
    localparam int MDone  = 3;

    int m_secs;
    int m_state;
    bit m_carry;
    bit m_hold;
    int m_lap_secs;

    function automatic logic [15:0] to_bcd(input int s);
        logic [15:0] r;
        r[15:12] = 4'(s / 600);
        r[11:8]  = 4'((s / 60) % 10);
        r[7:4]   = 4'((s % 60) / 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    always @(posedge clk) begin
        logic lap_in;
`ifdef LAP_HOLD_EN
        lap_in = bus.lap;
`else
        lap_in = 1'b0;
`endif
        m_carry = 1'b0;
        if (rst || bus.clear) begin
            m_secs  = 0;
            m_state = MIdle;
            m_hold  = 1'b0;
        end else if (bus.start_stop) begin
            if (m_state == MIdle || m_state == MPause) m_state = MRun;
            else if (m_state == MRun) m_state = MPause;
        end else if (m_state == MRun) begin
            if (lap_in) begin
                m_hold     = !m_hold;
                m_lap_secs = m_secs;
            end
            if (bus.tick) begin
                m_secs = (m_secs + 1) % 3600;
                if (m_secs == 0) m_carry = 1'b1;
                if (bus.target != 16'h0000 && to_bcd(m_secs) == bus.target) m_state = MDone;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [15:0] exp_val;
            exp_val = m_hold ? to_bcd(m_lap_secs) : to_bcd(m_secs);
`ifndef LAP_HOLD_EN
            exp_val = to_bcd(m_secs);
`endif
            check("model_value", bus.value, exp_val);
            check("model_carry", {15'd0, bus.carry}, {15'd0, m_carry});
            check("model_running", {15'd0, bus.running}, {15'd0, 1'(m_state == MRun)});
            check("model_target_hit", {15'd0, bus.target_hit}, {15'd0, 1'(m_state == MDone)});
        end
    end

    task automatic cyc(input logic t, input logic ss, input logic cl, input logic lp);
        bus.tick       = t;
        bus.start_stop = ss;
        bus.clear      = cl;
`ifdef LAP_HOLD_EN
        bus.lap        = lp;
`endif
        @(posedge clk);
        #1;
        bus.tick       = 1'b0;
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
`ifdef LAP_HOLD_EN
        bus.lap        = 1'b0;
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        bus.target = 16'h0000;

        // 1: reset for two cycles under random inputs
        for (int i = 0; i < 2; i++) begin
            bus.target = 16'($urandom);
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk_en = 1'b1;
        end
        rst = 1'b0;
        bus.target = 16'h0000;
        check("reset_value", bus.value, 16'h0000);
        check("reset_carry", {15'd0, bus.carry}, 16'h0000);
        check("reset_running", {15'd0, bus.running}, 16'h0000);
        check("reset_target_hit", {15'd0, bus.target_hit}, 16'h0000);

        // 2: run ten ticks, pause, ticks ignored
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        check("run10_value", bus.value, 16'h0010);
        check("run10_running", {15'd0, bus.running}, 16'h0001);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        check("pause_value", bus.value, 16'h0010);
        check("pause_running", {15'd0, bus.running}, 16'h0000);

        // 3: full-range wrap 59:59 -> 00:00
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3598);
        check("pre_wrap_value", bus.value, 16'h5958);
        ticks(1);
        check("at_5959_value", bus.value, 16'h5959);
        check("at_5959_carry", {15'd0, bus.carry}, 16'h0000);
        ticks(1);
        check("wrap_value", bus.value, 16'h0000);
        check("wrap_carry", {15'd0, bus.carry}, 16'h0001);
        check("wrap_running", {15'd0, bus.running}, 16'h0001);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("carry_one_cycle", {15'd0, bus.carry}, 16'h0000);

        // 4: target stop
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        bus.target = 16'h0003;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        check("target_value", bus.value, 16'h0003);
        check("target_hit", {15'd0, bus.target_hit}, 16'h0001);
        check("target_running", {15'd0, bus.running}, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        check("done_ignores_key", {15'd0, bus.target_hit}, 16'h0001);
        check("done_value", bus.value, 16'h0003);

        // 5: key priority over tick
        bus.target = 16'h0000;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(7);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("tick_ss_value", bus.value, 16'h0007);
        check("tick_ss_running", {15'd0, bus.running}, 16'h0000);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("clear_ss_value", bus.value, 16'h0000);
        check("clear_ss_running", {15'd0, bus.running}, 16'h0000);
        ticks(3);
        check("idle_ignores_tick", bus.value, 16'h0000);

`ifdef LAP_HOLD_EN
        // 6: lap hold
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(12);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(4);
        check("lap_held_value", bus.value, 16'h0012);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_release_value", bus.value, 16'h0016);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.target = 16'h0000;
                    1: bus.target = to_bcd(int'($urandom_range(1, 40)));
                    2: bus.target = to_bcd(int'($urandom_range(1, 3599)));
                    default: bus.target = 16'($urandom);
                endcase
            end
            rst = ($urandom_range(0, 999) == 0);
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
